// File: rtl/dmem_responder.sv
// Word-organised data RAM serving the CPU load/store port one request at a time,
// with byte/half/word lanes, load extension and request error flagging.
//
// state   | meaning
// IDLE    | waiting for rd/wr; request decoded and sampled here
// RD_WAIT | RAM word captured, forming the extended load result
// RESP    | ready (and err) pulse for one cycle, then back to IDLE
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_l,
  input  logic [31:0] mem_addr_w_i,
  input  logic [31:0] mem_data_w_i,
  input  logic        mem_wr_w_i_h,
  input  logic        mem_rd_w_i_h,
  input  logic [2:0]  mem_funct3_w_i,
  output logic [31:0] mem_data_w_o,
  output logic        mem_ready_w_o_h,
  output logic        mem_err_w_o_h
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t      r_state;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [31:0] r_data_o;
  logic        r_ready;
  logic        r_err;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_sample;
  logic          w_oor;
  logic          w_mis;
  logic          w_f3_bad;
  logic          w_err;
  logic          w_st_ok;
  logic          w_ld_ok;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld_result;

  assign w_off  = mem_addr_w_i - BASE_ADDR;
  assign w_idx  = w_off[AW+1:2];
  assign w_lane = mem_addr_w_i[1:0];

  // Gated by reset so nothing commits to RAM while the block is held in reset.
  assign w_sample = res_w_i_l && (r_state == IDLE) && (mem_rd_w_i_h || mem_wr_w_i_h);

  assign w_oor = (mem_addr_w_i < BASE_ADDR) || (w_off >= SPAN);
  assign w_mis = ((mem_funct3_w_i[1:0] == 2'b01) && mem_addr_w_i[0]) ||
                 ((mem_funct3_w_i[1:0] == 2'b10) && (mem_addr_w_i[1:0] != 2'b00));

  always_comb begin
    w_f3_bad = 1'b0;
    if (mem_wr_w_i_h)
      w_f3_bad = !(mem_funct3_w_i inside {3'b000, 3'b001, 3'b010});
    else
      w_f3_bad = !(mem_funct3_w_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  assign w_err   = (mem_rd_w_i_h && mem_wr_w_i_h) || w_oor || w_f3_bad || w_mis;
  assign w_st_ok = w_sample && mem_wr_w_i_h && !w_err;
  assign w_ld_ok = w_sample && mem_rd_w_i_h && !w_err;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_data_w_i;
    case (mem_funct3_w_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{mem_data_w_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{mem_data_w_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_data_w_i;
      end
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (w_st_ok) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
    if (w_ld_ok) r_rdata <= r_mem[w_idx];
  end

  always_comb begin
    w_byte      = r_rdata[{r_lane, 3'b000} +: 8];
    w_half      = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_ld_result = r_rdata;
    case (r_funct3)
      3'b000:  w_ld_result = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_result = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_result = {24'h0, w_byte};
      3'b101:  w_ld_result = {16'h0, w_half};
      default: w_ld_result = r_rdata;
    endcase
  end

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      r_state  <= IDLE;
      r_lane   <= 2'b00;
      r_funct3 <= 3'b000;
      r_data_o <= 32'h0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sample) begin
            r_lane   <= w_lane;
            r_funct3 <= mem_funct3_w_i;
            if (w_err) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else if (mem_wr_w_i_h) begin
              r_state <= RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          r_data_o <= w_ld_result;
          r_ready  <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_data_w_o    = r_data_o;
  assign mem_ready_w_o_h = r_ready;
  assign mem_err_w_o_h   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder: stores, loads, lane extension,
// error rejection and reset during a pending load.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [2:0]  f3;
  logic [31:0] dout;
  logic        ready;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk_w_i        (clk),
    .res_w_i_l      (rst_n),
    .mem_addr_w_i   (addr),
    .mem_data_w_i   (wdata),
    .mem_wr_w_i_h   (wr),
    .mem_rd_w_i_h   (rd),
    .mem_funct3_w_i (f3),
    .mem_data_w_o   (dout),
    .mem_ready_w_o_h(ready),
    .mem_err_w_o_h  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge; lat counts rising edges from the sampling edge
  // up to the first negedge where ready is seen.
  task automatic xfer(input string tag, input logic i_rd, input logic i_wr,
                      input logic [31:0] i_a, input logic [31:0] i_d, input logic [2:0] i_f3,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_data,
                      input logic chk_data);
    int lat;
    bit seen;
    @(negedge clk);
    rd = i_rd; wr = i_wr; addr = i_a; wdata = i_d; f3 = i_f3;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready) seen = 1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    if (chk_data) chk({tag, "_data"}, dout, exp_data);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'h0, ready}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = '0;

    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_data", dout, 32'h0);
    end

    // 2: word store/load
    xfer("sw10", 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 0, 32'h0, 1);
    xfer("lw10", 1, 0, 32'h10, 32'h0, 3'b010, 2, 0, 32'hDEADBEEF, 1);

    // 3: byte lane store and extensions
    xfer("sw10b", 0, 1, 32'h10, 32'h11223344, 3'b010, 1, 0, 32'h0, 0);
    xfer("sb13", 0, 1, 32'h13, 32'hFFFFFF80, 3'b000, 1, 0, 32'h0, 0);
    xfer("lb13", 1, 0, 32'h13, 32'h0, 3'b000, 2, 0, 32'hFFFFFF80, 1);
    xfer("lbu13", 1, 0, 32'h13, 32'h0, 3'b100, 2, 0, 32'h00000080, 1);
    xfer("lw10c", 1, 0, 32'h10, 32'h0, 3'b010, 2, 0, 32'h80223344, 1);
    xfer("lb12", 1, 0, 32'h12, 32'h0, 3'b000, 2, 0, 32'h00000022, 1);

    // 4: half lane store, extensions, misaligned half
    xfer("sw20", 0, 1, 32'h20, 32'hA5A5A5A5, 3'b010, 1, 0, 32'h0, 0);
    xfer("sh22", 0, 1, 32'h22, 32'h12348001, 3'b001, 1, 0, 32'h0, 0);
    xfer("lh22", 1, 0, 32'h22, 32'h0, 3'b001, 2, 0, 32'hFFFF8001, 1);
    xfer("lhu22", 1, 0, 32'h22, 32'h0, 3'b101, 2, 0, 32'h00008001, 1);
    xfer("lh21", 1, 0, 32'h21, 32'h0, 3'b001, 1, 1, 32'h00008001, 1);
    xfer("lw20", 1, 0, 32'h20, 32'h0, 3'b010, 2, 0, 32'h8001A5A5, 1);

    // 5: error requests leave RAM and data_o unchanged; top word is reachable
    xfer("sw30", 0, 1, 32'h30, 32'hCAFEF00D, 3'b010, 1, 0, 32'h0, 0);
    xfer("swoor", 0, 1, 32'd4096, 32'h0BADBAD0, 3'b010, 1, 1, 32'h8001A5A5, 1);
    xfer("lw3", 1, 0, 32'h3, 32'h0, 3'b010, 1, 1, 32'h8001A5A5, 1);
    xfer("rdwr", 1, 1, 32'h30, 32'h0, 3'b010, 1, 1, 32'h8001A5A5, 1);
    xfer("ldf011", 1, 0, 32'h30, 32'h0, 3'b011, 1, 1, 32'h8001A5A5, 1);
    xfer("stf100", 0, 1, 32'h30, 32'h0, 3'b100, 1, 1, 32'h8001A5A5, 1);
    xfer("swmis", 0, 1, 32'h32, 32'h0, 3'b010, 1, 1, 32'h8001A5A5, 1);
    xfer("lw30", 1, 0, 32'h30, 32'h0, 3'b010, 2, 0, 32'hCAFEF00D, 1);
    xfer("swtop", 0, 1, 32'hFFC, 32'h12345678, 3'b010, 1, 0, 32'h0, 0);
    xfer("lwtop", 1, 0, 32'hFFC, 32'h0, 3'b010, 2, 0, 32'h12345678, 1);
    xfer("lw0", 1, 0, 32'h0, 32'h0, 3'b010, 2, 0, 32'h0, 0);

    // 6: reset while the load is in RD_WAIT drops it
    @(negedge clk);
    rd = 1'b1; addr = 32'h30; f3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    rd = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    chk("midrst_data", dout, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_ready", {31'h0, ready}, 32'h0);
    end
    xfer("lw30r", 1, 0, 32'h30, 32'h0, 3'b010, 2, 0, 32'hCAFEF00D, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
